// File: rtl/serial_port_pkg.sv
// Shared SFR addresses, SCON bit positions and frame state codes for the
// mode-1 serial port.
package serial_port_pkg;

  localparam logic [7:0] SFR_SCON = 8'h98;
  localparam logic [7:0] SFR_SBUF = 8'h99;

  localparam int SCON_RI  = 0;
  localparam int SCON_TI  = 1;
  localparam int SCON_RB8 = 2;
  localparam int SCON_TB8 = 3;
  localparam int SCON_REN = 4;
  localparam int SCON_SM2 = 5;

  // Bit-addressable SCON occupies bit addresses 0x98..0x9F.
  localparam logic [4:0] SCON_BIT_BASE = 5'b10011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } frame_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_fsm.sv
// Mode-1 receiver: two-flop rxd synchroniser, 3-sample majority vote and
// the start/data/stop frame FSM. Reports a completed frame via a one-cycle load.
module serial_rx_fsm
  import serial_port_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         se,
  input  logic         rxd,
  input  logic         ren,
  input  logic         ri,
  input  logic         sm2,
  output logic         load,
  output logic [7:0]   data,
  output logic         stop_bit,
  output frame_state_t state_dbg
);

  frame_state_t state, state_next;
  logic       rxd_s1, rxd_s2, rxd_prev;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic       s7, s8;
  logic       vote, fall, at9, at15;

  always_comb begin
    vote       = majority3(s7, s8, rxd_s2);
    fall       = rxd_prev & ~rxd_s2;
    at9        = se && (cnt == 4'd9);
    at15       = se && (cnt == 4'd15);
    state_next = state;
    load       = 1'b0;
    if (!ren) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall) state_next = ST_START;
        ST_START: begin
          if (at9 && vote) state_next = ST_IDLE;
          else if (at15)   state_next = ST_DATA;
        end
        ST_DATA:  if (at15 && (bit_idx == 3'd7)) state_next = ST_STOP;
        ST_STOP: begin
          // Decide at count 9 and leave at once so a back-to-back start is seen.
          if (at9) begin
            state_next = ST_IDLE;
            load       = ~ri & (~sm2 | vote);
          end
        end
      endcase
    end
  end

  assign data      = shift;
  assign stop_bit  = vote;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      s7       <= 1'b0;
      s8       <= 1'b0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      state    <= state_next;
      if (state == ST_IDLE || state_next == ST_IDLE) begin
        cnt     <= 4'd0;
        bit_idx <= 3'd0;
      end else if (se) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7) s7 <= rxd_s2;
        if (cnt == 4'd8) s8 <= rxd_s2;
        if (state == ST_DATA && cnt == 4'd9)  shift   <= {vote, shift[7:1]};
        if (state == ST_DATA && cnt == 4'd15) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/serial_port.sv
// 8051 serial port, mode 1: SCON/SBUF SFRs, baud prescaler from the timer
// overflow, transmitter FSM, and the receiver sub-module.
module serial_port
  import serial_port_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_addr,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       tick_in,
  input  logic       smod,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] scon,
  output logic [7:0] sbuf_rx,
  output logic       int_req
);

  frame_state_t tx_state, tx_next, rx_state;
  logic       half, se;
  logic [3:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic       tx_armed, set_ti, tx_at15;
  logic       sbuf_wr, scon_byte_wr, scon_bit_wr;
  logic [7:0] scon_next, rx_data;
  logic       rx_load, rx_stop;

  assign se           = tick_in & (smod | half);
  assign sbuf_wr      = wr & ~wr_bit & (wr_addr == SFR_SBUF);
  assign scon_byte_wr = wr & ~wr_bit & (wr_addr == SFR_SCON);
  assign scon_bit_wr  = wr & wr_bit & (wr_addr[7:3] == SCON_BIT_BASE);
  assign int_req      = scon[SCON_TI] | scon[SCON_RI];

  always_comb begin
    tx_at15 = se && (tx_cnt == 4'd15);
    tx_next = tx_state;
    set_ti  = 1'b0;
    case (tx_state)
      ST_IDLE:  if (tx_armed && se) tx_next = ST_START;
      ST_START: if (tx_at15) tx_next = ST_DATA;
      ST_DATA: begin
        if (tx_at15 && (tx_bit == 3'd7)) begin
          tx_next = ST_STOP;
          set_ti  = 1'b1;
        end
      end
      ST_STOP:  if (tx_at15) tx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  // Hardware flag sets are applied after software writes so they win.
  always_comb begin
    scon_next = scon;
    if (scon_byte_wr) scon_next = data_in;
    if (scon_bit_wr)  scon_next[wr_addr[2:0]] = data_in[0];
    if (set_ti)       scon_next[SCON_TI] = 1'b1;
    if (rx_load) begin
      scon_next[SCON_RI]  = 1'b1;
      scon_next[SCON_RB8] = rx_stop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      half     <= 1'b0;
      scon     <= 8'd0;
      sbuf_rx  <= 8'd0;
      tx_state <= ST_IDLE;
      tx_cnt   <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_armed <= 1'b0;
    end else begin
      if (tick_in) half <= ~half;
      scon     <= scon_next;
      if (rx_load) sbuf_rx <= rx_data;
      tx_state <= tx_next;
      if (tx_state == ST_IDLE) begin
        tx_cnt <= 4'd0;
        tx_bit <= 3'd0;
        // A write landing on the cycle TX commits to START is dropped.
        if (tx_next == ST_START) begin
          tx_armed <= 1'b0;
        end else if (sbuf_wr) begin
          tx_shift <= data_in;
          tx_armed <= 1'b1;
        end
      end else if (se) begin
        tx_cnt <= tx_cnt + 4'd1;
        if (tx_state == ST_DATA && tx_cnt == 4'd15) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_bit   <= tx_bit + 3'd1;
        end
      end
    end
  end

  serial_rx_fsm u_rx (
    .clock     (clock),
    .reset     (reset),
    .se        (se),
    .rxd       (rxd),
    .ren       (scon[SCON_REN]),
    .ri        (scon[SCON_RI]),
    .sm2       (scon[SCON_SM2]),
    .load      (rx_load),
    .data      (rx_data),
    .stop_bit  (rx_stop),
    .state_dbg (rx_state)
  );

endmodule
